cdb_scheduler: RTL and testbench
================================

Name: cdb_scheduler

Overview:
- Sequencer in front of the two-wide common data bus (CDB).
- Each functional unit (FU) result enters a one-entry holding slot. Two slots per cycle are granted in rotating-priority order. Winners are broadcast on registered CDB outputs.
- Per-FU ready is the backpressure signal. It replaces the purely combinational per-FU stall vector.

Parameters:
- NUM_FU, 8, number of requesting FU result ports.
- CDB_WIDTH, 2, broadcast slots per cycle. Logic is specified for exactly 2.
- TAG_W, 6, physical register tag width (PHYS_REG).
- DATA_W, 64, result width (DATA).

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 resets).
- flush  in  1  synchronous squash (mispredict recovery).
- fub_valid  in  NUM_FU  FU i presents a result.
- fub_tagDest  in  NUM_FU x TAG_W  destination tag per FU.
- fub_result  in  NUM_FU x DATA_W  result value per FU.
- fub_ready  out  NUM_FU  FU i result is accepted at this edge if fub_valid[i].
- cdb_rd_en  out  CDB_WIDTH  broadcast slot k valid.
- cdb_rd  out  CDB_WIDTH x TAG_W  broadcast tag per slot.
- cdb_reg_value  out  CDB_WIDTH x DATA_W  broadcast value per slot.

Behaviour:
- State:
  - hold_v[i], hold_tag[i], hold_data[i] per FU.
  - rr_ptr, $clog2(NUM_FU) bits.
  - Registered CDB outputs.
- Reset (async assert, synchronous-release sampling):
  - hold_v=0, rr_ptr=0.
  - cdb_rd_en=0, cdb_rd=0, cdb_reg_value=0.
  - fub_ready therefore reads all ones.
- Pick (combinational, from current hold_v):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NUM_FU.
  - The first held entry is g0 and drives slot 0. The second held entry is g1 and drives slot 1.
  - If fewer than two entries are held, the unused slots are idle.
- fub_ready[i] = !flush && (!hold_v[i] || granted[i]). A granted slot refills in the same cycle with no bubble.
- Per edge, when flush=0:
  - Granted entries clear.
  - Accepted inputs (fub_valid && fub_ready) load hold.
  - Grant-clear and load of the same index at the same edge leave hold_v=1 with the new tag and data.
- Broadcast, per edge:
  - cdb_rd_en[k] <= slot k picked.
  - cdb_rd[k] and cdb_reg_value[k] <= the picked entry's tag and value.
  - Idle slots drive tag 0 and value 0.
- Pointer:
  - If any grant, rr_ptr <= (index of last granted entry + 1) mod NUM_FU. Wrap from NUM_FU-1 to 0.
  - If no grant, rr_ptr is unchanged.
- Latency: a result accepted at edge N is broadcast at edge N+1 at the earliest, i.e. visible on the CDB after edge N+1.
- Fairness: any held entry is broadcast within ceil(NUM_FU/2)=4 cycles.
- Ordering and loss: an FU holding fub_valid while fub_ready=0 loses nothing. Its later result is never broadcast before its earlier one.
- Flush (synchronous, highest priority over accept and grant):
  - Next edge: hold_v=0, cdb_rd_en=0, rr_ptr=0.
  - Inputs in the flush cycle are dropped.
- Reset mid-operation discards all held entries and any in-flight broadcast immediately.
- Tags are not interpreted. Tag 0 is broadcast like any other value.

Decomposition:
- Shared package:
  - PHYS_REG (logic [TAG_W-1:0]) and DATA (logic [DATA_W-1:0]) typedefs.
  - NUM_FU and CDB_WIDTH constants.
- Sub-module: cdb_rr_picker, purely combinational.
  - Inputs: req vector, rr_ptr.
  - Outputs: g0/g1 one-hot, g0/g1 valid, next_ptr.
  - Reused by the verification model.

Test Plan:
- Reset: hold FU0..4, assert reset=0 mid-cycle -> cdb_rd_en=2'b00 immediately. After release, fub_ready=8'hFF and no stale broadcast.
- Single: FU3 valid, tag 17, data 64'hDEAD at edge 1 -> after edge 2: cdb_rd_en=2'b01, cdb_rd[0]=17, cdb_reg_value[0]=64'hDEAD. Then rr_ptr=4.
- Saturation: all 8 FUs valid for one cycle, tag i+8, data i -> four broadcast cycles of tag pairs (8,9),(10,11),(12,13),(14,15) on slots 0/1. fub_ready stays 0 for each waiting FU until its grant cycle.
- Rotation: rr_ptr=2, FU0 and FU5 held -> slot0 tag from FU5, slot1 tag from FU0. Then rr_ptr=1.
- Backpressure: FU2 held, not granted, fub_valid[2] stays 1 with new tag 30 -> fub_ready[2]=0. The old tag is broadcast first. Tag 30 is accepted at the grant edge and broadcast one cycle later. Nothing is lost or duplicated.
- Flush: 5 entries held plus FU6 valid with flush=1 -> next edge cdb_rd_en=0, hold_v=0, rr_ptr=0. FU6's result is never broadcast.

Source files
------------

// File: rtl/cdb_scheduler_pkg.sv
// Shared types and sizing for the CDB scheduler and its rotating-priority picker.
package cdb_scheduler_pkg;

  localparam int unsigned NUM_FU    = 8;
  localparam int unsigned CDB_WIDTH = 2;
  localparam int unsigned TAG_W     = 6;
  localparam int unsigned DATA_W    = 64;
  localparam int unsigned PTR_W     = $clog2(NUM_FU);

  typedef logic [TAG_W-1:0]  PHYS_REG;
  typedef logic [DATA_W-1:0] DATA;

endpackage

// File: rtl/cdb_rr_picker.sv
// Combinational two-winner rotating-priority picker: scans from rr_ptr and returns the first
// two requesters as one-hot grants plus the pointer that follows the last winner.
module cdb_rr_picker
  import cdb_scheduler_pkg::*;
(
  input  logic [NUM_FU-1:0] req,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [NUM_FU-1:0] g0,
  output logic [NUM_FU-1:0] g1,
  output logic              g0_valid,
  output logic              g1_valid,
  output logic [PTR_W-1:0]  next_ptr
);

  always_comb begin
    int unsigned idx;
    idx      = 0;
    g0       = '0;
    g1       = '0;
    g0_valid = 1'b0;
    g1_valid = 1'b0;
    next_ptr = rr_ptr;
    for (int unsigned j = 0; j < NUM_FU; j++) begin
      idx = (32'(rr_ptr) + j) % NUM_FU;
      if (req[idx]) begin
        if (!g0_valid) begin
          g0_valid = 1'b1;
          g0[idx]  = 1'b1;
          next_ptr = PTR_W'((idx + 1) % NUM_FU);
        end else if (!g1_valid) begin
          g1_valid = 1'b1;
          g1[idx]  = 1'b1;
          next_ptr = PTR_W'((idx + 1) % NUM_FU);
        end
      end
    end
  end

endmodule

// File: rtl/cdb_scheduler.sv
// Two-wide CDB sequencer: one holding slot per FU, two rotating-priority grants per cycle,
// registered broadcast outputs, per-FU ready as backpressure.
module cdb_scheduler
  import cdb_scheduler_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic [NUM_FU-1:0]                   fub_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]        fub_tagDest,
  input  logic [NUM_FU-1:0][DATA_W-1:0]       fub_result,
  output logic [NUM_FU-1:0]                   fub_ready,
  output logic [CDB_WIDTH-1:0]                cdb_rd_en,
  output logic [CDB_WIDTH-1:0][TAG_W-1:0]     cdb_rd,
  output logic [CDB_WIDTH-1:0][DATA_W-1:0]    cdb_reg_value
);

  logic [NUM_FU-1:0]          hold_v_q;
  PHYS_REG [NUM_FU-1:0]       hold_tag_q;
  DATA [NUM_FU-1:0]           hold_data_q;
  logic [PTR_W-1:0]           rr_ptr_q;

  logic [NUM_FU-1:0]          g0, g1, granted, load;
  logic                       g0_valid, g1_valid;
  logic [PTR_W-1:0]           next_ptr;
  PHYS_REG [CDB_WIDTH-1:0]    sel_tag;
  DATA [CDB_WIDTH-1:0]        sel_data;

  cdb_rr_picker u_picker (
    .req      (hold_v_q),
    .rr_ptr   (rr_ptr_q),
    .g0       (g0),
    .g1       (g1),
    .g0_valid (g0_valid),
    .g1_valid (g1_valid),
    .next_ptr (next_ptr)
  );

  assign granted   = g0 | g1;
  // A granted slot may refill at the same edge it drains.
  assign fub_ready = {NUM_FU{!flush}} & (~hold_v_q | granted);
  assign load      = fub_valid & fub_ready;

  // One-hot OR mux; idle slots fall out as zero.
  always_comb begin
    sel_tag  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_FU; i++) begin
      if (g0[i]) begin
        sel_tag[0]  = sel_tag[0] | hold_tag_q[i];
        sel_data[0] = sel_data[0] | hold_data_q[i];
      end
      if (g1[i]) begin
        sel_tag[1]  = sel_tag[1] | hold_tag_q[i];
        sel_data[1] = sel_data[1] | hold_data_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_v_q      <= '0;
      hold_tag_q    <= '0;
      hold_data_q   <= '0;
      rr_ptr_q      <= '0;
      cdb_rd_en     <= '0;
      cdb_rd        <= '0;
      cdb_reg_value <= '0;
    end else if (flush) begin
      hold_v_q      <= '0;
      rr_ptr_q      <= '0;
      cdb_rd_en     <= '0;
      cdb_rd        <= '0;
      cdb_reg_value <= '0;
    end else begin
      hold_v_q <= (hold_v_q & ~granted) | load;
      for (int unsigned i = 0; i < NUM_FU; i++) begin
        if (load[i]) begin
          hold_tag_q[i]  <= fub_tagDest[i];
          hold_data_q[i] <= fub_result[i];
        end
      end
      rr_ptr_q      <= next_ptr;
      cdb_rd_en     <= {g1_valid, g0_valid};
      cdb_rd        <= sel_tag;
      cdb_reg_value <= sel_data;
    end
  end

endmodule

// File: tb/tb_cdb_scheduler.sv
// Directed bench for cdb_scheduler: cycle table of inputs and hand-computed CDB/ready values,
// followed by a mid-cycle asynchronous reset sequence.
module tb_cdb_scheduler;

  logic                    clk;
  logic                    reset;
  logic                    flush;
  logic [7:0]              fub_valid;
  logic [7:0][5:0]         fub_tagDest;
  logic [7:0][63:0]        fub_result;
  logic [7:0]              fub_ready;
  logic [1:0]              cdb_rd_en;
  logic [1:0][5:0]         cdb_rd;
  logic [1:0][63:0]        cdb_reg_value;

  int n_vec;
  int n_miss;

  cdb_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .fub_valid     (fub_valid),
    .fub_tagDest   (fub_tagDest),
    .fub_result    (fub_result),
    .fub_ready     (fub_ready),
    .cdb_rd_en     (cdb_rd_en),
    .cdb_rd        (cdb_rd),
    .cdb_reg_value (cdb_reg_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FU i presents tag tb+i and data db+i when its valid bit is set.
  typedef struct {
    logic [7:0]  valid;
    logic [5:0]  tb;
    logic [63:0] db;
    logic        fl;
    logic [7:0]  ready;
    logic [1:0]  en;
    logic [5:0]  rd0;
    logic [5:0]  rd1;
    logic [63:0] v0;
    logic [63:0] v1;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic [7:0] valid, input logic [5:0] tb,
                              input logic [63:0] db, input logic fl, input logic [7:0] ready,
                              input logic [1:0] en, input logic [5:0] rd0,
                              input logic [5:0] rd1, input logic [63:0] v0,
                              input logic [63:0] v1);
    vec_t v;
    v.valid = valid; v.tb = tb; v.db = db; v.fl = fl; v.ready = ready;
    v.en = en; v.rd0 = rd0; v.rd1 = rd1; v.v0 = v0; v.v1 = v1;
    return v;
  endfunction

  task automatic drive(input logic [7:0] valid, input logic [5:0] tb, input logic [63:0] db,
                       input logic fl);
    fub_valid = valid;
    flush     = fl;
    for (int i = 0; i < 8; i++) begin
      fub_tagDest[i] = tb + 6'(i);
      fub_result[i]  = db + 64'(i);
    end
  endtask

  task automatic check_ready(input string name, input logic [7:0] exp);
    n_vec++;
    if (fub_ready !== exp) begin
      n_miss++;
      $display("FAIL %s fub_ready: got %h want %h", name, fub_ready, exp);
    end
  endtask

  task automatic check_cdb(input string name, input logic [1:0] en, input logic [5:0] rd0,
                           input logic [5:0] rd1, input logic [63:0] v0, input logic [63:0] v1);
    n_vec++;
    if (cdb_rd_en !== en || cdb_rd[0] !== rd0 || cdb_rd[1] !== rd1 ||
        cdb_reg_value[0] !== v0 || cdb_reg_value[1] !== v1) begin
      n_miss++;
      $display("FAIL %s cdb: got en=%b rd=%0d/%0d val=%0h/%0h want en=%b rd=%0d/%0d val=%0h/%0h",
               name, cdb_rd_en, cdb_rd[0], cdb_rd[1], cdb_reg_value[0], cdb_reg_value[1],
               en, rd0, rd1, v0, v1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    string nm;
    n_vec  = 0;
    n_miss = 0;

    // saturation from reset (ptr 0)
    tbl[0]  = mk(8'hFF, 6'd8,  64'd0,   0, 8'hFF, 2'b00, 0, 0, 0, 0);
    tbl[1]  = mk(8'h00, 6'd0,  64'd0,   0, 8'h03, 2'b11, 8, 9, 0, 1);
    tbl[2]  = mk(8'h00, 6'd0,  64'd0,   0, 8'h0F, 2'b11, 10, 11, 2, 3);
    tbl[3]  = mk(8'h00, 6'd0,  64'd0,   0, 8'h3F, 2'b11, 12, 13, 4, 5);
    tbl[4]  = mk(8'h00, 6'd0,  64'd0,   0, 8'hFF, 2'b11, 14, 15, 6, 7);
    // single: FU3 tag 17 data DEAD, leaves ptr 4
    tbl[5]  = mk(8'h08, 6'd14, 64'hDEAD - 64'd3, 0, 8'hFF, 2'b00, 0, 0, 0, 0);
    tbl[6]  = mk(8'h00, 6'd0,  64'd0,   0, 8'hFF, 2'b01, 17, 0, 64'hDEAD, 0);
    // FU1 grant moves ptr to 2, then rotation with FU0/FU5
    tbl[7]  = mk(8'h02, 6'd20, 64'd100, 0, 8'hFF, 2'b00, 0, 0, 0, 0);
    tbl[8]  = mk(8'h21, 6'd40, 64'd200, 0, 8'hFF, 2'b01, 21, 0, 101, 0);
    tbl[9]  = mk(8'h00, 6'd0,  64'd0,   0, 8'hFF, 2'b11, 45, 40, 205, 200);
    // ptr now 1: FU1 must outrank FU0
    tbl[10] = mk(8'h03, 6'd50, 64'd300, 0, 8'hFF, 2'b00, 0, 0, 0, 0);
    tbl[11] = mk(8'h00, 6'd0,  64'd0,   0, 8'hFF, 2'b11, 51, 50, 301, 300);
    // FU6 alone moves ptr to 7, then backpressure on FU2
    tbl[12] = mk(8'h40, 6'd50, 64'd400, 0, 8'hFF, 2'b00, 0, 0, 0, 0);
    tbl[13] = mk(8'h00, 6'd0,  64'd0,   0, 8'hFF, 2'b01, 56, 0, 406, 0);
    tbl[14] = mk(8'h07, 6'd20, 64'd500, 0, 8'hFF, 2'b00, 0, 0, 0, 0);
    tbl[15] = mk(8'h04, 6'd28, 64'd600, 0, 8'hFB, 2'b11, 20, 21, 500, 501);
    tbl[16] = mk(8'h04, 6'd28, 64'd600, 0, 8'hFF, 2'b01, 22, 0, 502, 0);
    tbl[17] = mk(8'h00, 6'd0,  64'd0,   0, 8'hFF, 2'b01, 30, 0, 602, 0);
    tbl[18] = mk(8'h00, 6'd0,  64'd0,   0, 8'hFF, 2'b00, 0, 0, 0, 0);
    // flush with five held plus FU6 presenting
    tbl[19] = mk(8'h1F, 6'd1,  64'd700, 0, 8'hFF, 2'b00, 0, 0, 0, 0);
    tbl[20] = mk(8'h40, 6'd10, 64'd800, 1, 8'h00, 2'b00, 0, 0, 0, 0);
    tbl[21] = mk(8'h00, 6'd0,  64'd0,   0, 8'hFF, 2'b00, 0, 0, 0, 0);
    // ptr back at 0: FU1 before FU7
    tbl[22] = mk(8'h82, 6'd30, 64'd900, 0, 8'hFF, 2'b00, 0, 0, 0, 0);
    tbl[23] = mk(8'h00, 6'd0,  64'd0,   0, 8'hFF, 2'b11, 31, 37, 901, 907);
    // tag 0 is a real broadcast
    tbl[24] = mk(8'h01, 6'd0,  64'd5,   0, 8'hFF, 2'b00, 0, 0, 0, 0);
    tbl[25] = mk(8'h00, 6'd0,  64'd0,   0, 8'hFF, 2'b01, 0, 0, 5, 0);

    reset = 1'b0;
    drive(8'h00, 6'd0, 64'd0, 1'b0);
    step();
    step();
    check_cdb("reset_state", 2'b00, 0, 0, 0, 0);
    #1;
    check_ready("reset_ready", 8'hFF);
    reset = 1'b1;
    step();

    for (int r = 0; r < NV; r++) begin
      nm = $sformatf("row%0d", r);
      drive(tbl[r].valid, tbl[r].tb, tbl[r].db, tbl[r].fl);
      #1;
      check_ready(nm, tbl[r].ready);
      step();
      check_cdb(nm, tbl[r].en, tbl[r].rd0, tbl[r].rd1, tbl[r].v0, tbl[r].v1);
    end

    // mid-cycle reset while a broadcast is on the bus (ptr is 1: FU1, FU2 win)
    drive(8'h1F, 6'd1, 64'd1000, 1'b0);
    step();
    drive(8'h00, 6'd0, 64'd0, 1'b0);
    step();
    check_cdb("pre_reset_bcast", 2'b11, 2, 3, 1001, 1002);
    #3;
    reset = 1'b0;
    #1;
    check_cdb("async_reset", 2'b00, 0, 0, 0, 0);
    check_ready("async_reset_ready", 8'hFF);
    #2;
    reset = 1'b1;
    step();
    check_cdb("post_reset_1", 2'b00, 0, 0, 0, 0);
    check_ready("post_reset_ready", 8'hFF);
    step();
    check_cdb("post_reset_2", 2'b00, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
